// File: rtl/gpio_out_pkg.sv
// gpio_out_pkg
//   Shared definitions for the memory-mapped output port bank:
//   - register offsets inside a channel's window
//   - the fixed per-channel address stride
//   - byte-lane helpers used by every byte-enabled register write
package gpio_out_pkg;

  localparam int REG_DATA   = 0;
  localparam int REG_SET    = 1;
  localparam int REG_CLR    = 2;
  localparam int REG_TGL    = 3;
  localparam int REG_PMASK  = 4;
  localparam int REG_PLEN   = 5;
  localparam int REG_STATUS = 6;
  localparam int REG_RSVD   = 7;

  // Number of writable registers; the reserved slot gets no strobe.
  localparam int NUM_WR_REGS = REG_STATUS + 1;

  // Every channel owns an 8-word address window.
  localparam int CH_STRIDE = 8;

  typedef enum logic [2:0] {
    OFF_DATA   = 3'd0,
    OFF_SET    = 3'd1,
    OFF_CLR    = 3'd2,
    OFF_TGL    = 3'd3,
    OFF_PMASK  = 3'd4,
    OFF_PLEN   = 3'd5,
    OFF_STATUS = 3'd6,
    OFF_RSVD   = 3'd7
  } reg_off_e;

  // Expand the two byte enables into a 16-bit lane mask.
  function automatic logic [15:0] byte_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  // Replace only the enabled byte lanes of cur with the matching lanes of wdata.
  function automatic logic [15:0] merge_bytes(input logic [15:0] cur,
                                              input logic [15:0] wdata,
                                              input logic [1:0]  be);
    logic [15:0] m;
    m = byte_mask(be);
    return (cur & ~m) | (wdata & m);
  endfunction

endpackage

// File: rtl/gpio_out_bank_channel.sv
// gpio_out_channel
//   One 16-bit output channel: DATA and PMASK registers, one-shot pulse
//   counter, sticky done flag, registered pin output and readback mux.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   wr_data      bus write data
//   byte_en      byte write enables ([0] = bits 7:0, [1] = bits 15:8)
//   wr_stb       one decoded write strobe per register offset 0..6
//   rd_reg       register offset being read
//   port         registered pin output
//   rd_data      combinational readback of rd_reg
//   done         sticky pulse-complete flag
module gpio_out_channel
  import gpio_out_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            wr_data,
  input  logic [1:0]             byte_en,
  input  logic [NUM_WR_REGS-1:0] wr_stb,
  input  reg_off_e               rd_reg,
  output logic [15:0]            port,
  output logic [15:0]            rd_data,
  output logic                   done
);

  logic [15:0]      data_q, data_nxt;
  logic [15:0]      pmask_q, pmask_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             done_q, done_nxt;
  logic [15:0]      port_q, port_nxt;
  logic [15:0]      lane;
  logic             plen_wr;

  assign lane    = wr_data & byte_mask(byte_en);
  // The pulse length only changes on a full-word write.
  assign plen_wr = wr_stb[REG_PLEN] && (byte_en == 2'b11);

  always_comb begin
    data_nxt  = data_q;
    pmask_nxt = pmask_q;
    cnt_nxt   = cnt_q;
    done_nxt  = done_q;

    if (wr_stb[REG_DATA])  data_nxt  = merge_bytes(data_q, wr_data, byte_en);
    if (wr_stb[REG_SET])   data_nxt  = data_q | lane;
    if (wr_stb[REG_CLR])   data_nxt  = data_q & ~lane;
    if (wr_stb[REG_TGL])   data_nxt  = data_q ^ lane;
    if (wr_stb[REG_PMASK]) pmask_nxt = merge_bytes(pmask_q, wr_data, byte_en);

    if (wr_stb[REG_STATUS] && byte_en[0] && wr_data[0]) done_nxt = 1'b0;

    // A PLEN write (load, retrigger or abort) overrides the countdown, so
    // a reload on the expiry cycle suppresses done. Expiry is applied after
    // the W1C clear so that a simultaneous clear loses to the set.
    if (plen_wr) begin
      cnt_nxt = wr_data[CNT_W-1:0];
    end else if (cnt_q != '0) begin
      cnt_nxt = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) done_nxt = 1'b1;
    end

    // The pin value is built from the post-edge register values so a write
    // shows on the pins in the same cycle the register changes.
    port_nxt = data_nxt ^ ((cnt_nxt != '0) ? pmask_nxt : 16'h0000);
  end

  // ---- register stage ----
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      pmask_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      port_q  <= '0;
    end else begin
      data_q  <= data_nxt;
      pmask_q <= pmask_nxt;
      cnt_q   <= cnt_nxt;
      done_q  <= done_nxt;
      port_q  <= port_nxt;
    end
  end

  assign port = port_q;
  assign done = done_q;

  always_comb begin
    rd_data = '0;
    case (rd_reg)
      OFF_DATA, OFF_SET, OFF_CLR, OFF_TGL: rd_data = data_q;
      OFF_PMASK:                           rd_data = pmask_q;
      OFF_PLEN:                            rd_data = 16'(cnt_q);
      OFF_STATUS:                          rd_data = {15'h0000, done_q};
      default:                             rd_data = '0;
    endcase
  end

endmodule

// File: rtl/gpio_out_bank.sv
// gpio_out_bank
//   Memory-mapped bank of NCH 16-bit output channels on the data bus.
//   Channel c occupies BASE_ADDR + 8c .. BASE_ADDR + 8c + 7.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus_in       write data
//   address      word address
//   MemWrite     byte write enables; nonzero means a write this cycle
//   rd_data      combinational readback, 0 for unmapped addresses
//   io_port      pin outputs, channel c in bits [16c+15:16c]
//   pulse_done   per-channel sticky pulse-complete flags
module gpio_out_bank
  import gpio_out_pkg::*;
#(
  parameter int          NCH       = 2,
  parameter logic [15:0] BASE_ADDR = 16'h0008,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       bus_in,
  input  logic [15:0]       address,
  input  logic [1:0]        MemWrite,
  output logic [15:0]       rd_data,
  output logic [NCH*16-1:0] io_port,
  output logic [NCH-1:0]    pulse_done
);

  localparam logic [15:0] SPAN = 16'(NCH * CH_STRIDE);

  logic [15:0]    offset;
  logic           mapped;
  logic [2:0]     ch_idx;
  reg_off_e       reg_sel;
  logic           wr_any;
  logic [NCH-1:0] ch_sel;
  logic [15:0]    ch_rd [NCH];

  // The lower-bound test stops addresses below the base from wrapping
  // into the window through the subtraction.
  assign offset  = address - BASE_ADDR;
  assign mapped  = (address >= BASE_ADDR) && (offset < SPAN);
  assign ch_idx  = offset[5:3];
  assign reg_sel = reg_off_e'(offset[2:0]);
  assign wr_any  = |MemWrite;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [NUM_WR_REGS-1:0] stb;

    assign ch_sel[c] = mapped && (ch_idx == 3'(c));

    // Offset 7 is reserved and never strobes anything.
    always_comb begin
      stb = '0;
      for (int r = 0; r < NUM_WR_REGS; r++) begin
        stb[r] = ch_sel[c] && wr_any && (offset[2:0] == 3'(r));
      end
    end

    gpio_out_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .wr_data(bus_in),
      .byte_en(MemWrite),
      .wr_stb (stb),
      .rd_reg (reg_sel),
      .port   (io_port[16*c +: 16]),
      .rd_data(ch_rd[c]),
      .done   (pulse_done[c])
    );
  end

  // At most one channel is selected, so an OR of gated readbacks is a mux.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_sel[c]) rd_data = rd_data | ch_rd[c];
    end
  end

endmodule

// File: tb/tb_gpio_out_bank.sv
// Scoreboard bench for gpio_out_bank: a behavioural model predicts readback
// (pre-edge) and pins/done flags (post-edge) for every driven cycle.
module tb_gpio_out_bank;

  localparam int          NCH   = 2;
  localparam logic [15:0] BASE  = 16'h0008;
  localparam int          CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [15:0]       bus_in;
  logic [15:0]       address;
  logic [1:0]        MemWrite;
  logic [15:0]       rd_data;
  logic [NCH*16-1:0] io_port;
  logic [NCH-1:0]    pulse_done;

  gpio_out_bank #(.NCH(NCH), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .address(address),
    .MemWrite(MemWrite), .rd_data(rd_data), .io_port(io_port),
    .pulse_done(pulse_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH*16-1:0] io;
    logic [NCH-1:0]    dn;
    logic [15:0]       rd;
    bit                chk_rd;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  int unsigned m_data [NCH];
  int unsigned m_pmask[NCH];
  int unsigned m_cnt  [NCH];
  bit          m_done [NCH];

  function automatic int decode_ch(input logic [15:0] a);
    int ia;
    ia = int'(a);
    if (ia >= int'(BASE) && ia < int'(BASE) + NCH * 8) return (ia - int'(BASE)) / 8;
    return -1;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    int ch, r;
    ch = decode_ch(a);
    if (ch < 0) return 16'h0000;
    r = (int'(a) - int'(BASE)) % 8;
    if (r <= 3) return 16'(m_data[ch]);
    if (r == 4) return 16'(m_pmask[ch]);
    if (r == 5) return 16'(m_cnt[ch]);
    if (r == 6) return m_done[ch] ? 16'h0001 : 16'h0000;
    return 16'h0000;
  endfunction

  function automatic void model_step(input bit rst, input logic [15:0] a,
                                     input logic [15:0] d, input logic [1:0] be);
    int ch, r;
    int unsigned mask, wd, newcnt;
    bit plen_wr;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_data[c] = 0; m_pmask[c] = 0; m_cnt[c] = 0; m_done[c] = 0;
      end
      return;
    end
    ch = decode_ch(a);
    r = (int'(a) - int'(BASE)) % 8;
    mask = (be[0] ? 32'h00FF : 0) + (be[1] ? 32'hFF00 : 0);
    wd = int'(d);
    for (int c = 0; c < NCH; c++) begin
      plen_wr = 0;
      newcnt = 0;
      if (c == ch) begin
        case (r)
          0: m_data[c]  = (m_data[c] & ~mask & 32'hFFFF) | (wd & mask);
          1: m_data[c]  = m_data[c] | (wd & mask);
          2: m_data[c]  = m_data[c] & ~(wd & mask) & 32'hFFFF;
          3: m_data[c]  = m_data[c] ^ (wd & mask);
          4: m_pmask[c] = (m_pmask[c] & ~mask & 32'hFFFF) | (wd & mask);
          5: if (be == 2'b11) begin plen_wr = 1; newcnt = wd % (1 << CNT_W); end
          6: if (be[0] && d[0]) m_done[c] = 0;
          default: ;
        endcase
      end
      if (plen_wr) m_cnt[c] = newcnt;
      else if (m_cnt[c] > 0) begin
        m_cnt[c] = m_cnt[c] - 1;
        if (m_cnt[c] == 0) m_done[c] = 1;
      end
    end
  endfunction

  // Drive one bus cycle and queue the predicted response.
  task automatic op(input bit rst, input logic [15:0] a,
                    input logic [15:0] d, input logic [1:0] be);
    exp_t e;
    @(negedge clk);
    reset = rst; address = a; bus_in = d; MemWrite = be;
    e.chk_rd = !rst;
    e.rd = model_read(a);
    model_step(rst, a, d, be);
    for (int c = 0; c < NCH; c++) begin
      e.io[16*c +: 16] = 16'(m_data[c] ^ ((m_cnt[c] > 0) ? m_pmask[c] : 0));
      e.dn[c] = m_done[c];
    end
    q.push_back(e);
  endtask

  task automatic idle(input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) op(0, a, 16'h0000, 2'b00);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: readback sampled mid-low-phase, pins/done just after the edge.
  initial begin
    logic [15:0] rd_s;
    exp_t e;
    forever begin
      @(negedge clk);
      #2 rd_s = rd_data;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_rd) check("rd_data", 64'(rd_s), 64'(e.rd));
        check("io_port", 64'(io_port), 64'(e.io));
        check("pulse_done", 64'(pulse_done), 64'(e.dn));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; address = '0; bus_in = '0; MemWrite = 2'b00;
    for (int c = 0; c < NCH; c++) begin
      m_data[c] = 0; m_pmask[c] = 0; m_cnt[c] = 0; m_done[c] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    op(1, 16'h0000, 16'h0000, 2'b00);
    op(1, 16'h0008, 16'h0000, 2'b00);

    // Channel 0 DATA and byte-enabled atomic ops
    op(0, 16'h0008, 16'hA5C3, 2'b11);
    idle(16'h0008, 1);
    op(0, 16'h0008, 16'hFF00, 2'b01);
    op(0, 16'h0009, 16'h00F0, 2'b11);
    op(0, 16'h000A, 16'hA000, 2'b11);
    op(0, 16'h000B, 16'hFFFF, 2'b10);
    idle(16'h0008, 1);

    // Channel 1 pulse of 5, then W1C
    op(0, 16'h0010, 16'h0000, 2'b11);
    op(0, 16'h0014, 16'h0001, 2'b11);
    op(0, 16'h0015, 16'h0005, 2'b11);
    idle(16'h0016, 7);
    op(0, 16'h0016, 16'h0001, 2'b11);
    idle(16'h0016, 1);

    // Retrigger 10 -> 3 after 4 cycles
    op(0, 16'h0015, 16'd10, 2'b11);
    idle(16'h0015, 3);
    op(0, 16'h0015, 16'd3, 2'b11);
    idle(16'h0016, 5);
    op(0, 16'h0016, 16'h0001, 2'b01);

    // Abort
    op(0, 16'h0015, 16'd10, 2'b11);
    idle(16'h0015, 2);
    op(0, 16'h0015, 16'd0, 2'b11);
    idle(16'h0016, 3);

    // Reload on the expiry edge
    op(0, 16'h0015, 16'd3, 2'b11);
    idle(16'h0015, 2);
    op(0, 16'h0015, 16'd2, 2'b11);
    idle(16'h0016, 4);
    op(0, 16'h0016, 16'h0001, 2'b11);

    // W1C on the expiry edge
    op(0, 16'h0015, 16'd3, 2'b11);
    idle(16'h0015, 2);
    op(0, 16'h0016, 16'h0001, 2'b11);
    idle(16'h0016, 2);

    // Reset mid-pulse, with a write in the reset cycle
    op(0, 16'h0015, 16'd8, 2'b11);
    idle(16'h0015, 1);
    op(1, 16'h0010, 16'hFFFF, 2'b11);
    idle(16'h0010, 2);

    // Decode: channel 2, reserved slot, address 0, partial PLEN
    op(0, 16'h0010, 16'h1234, 2'b11);
    op(0, 16'h0018, 16'hFFFF, 2'b11);
    op(0, 16'h000F, 16'hFFFF, 2'b11);
    op(0, 16'h0000, 16'hFFFF, 2'b11);
    idle(16'h0018, 1);
    idle(16'h000F, 1);
    idle(16'h0000, 1);
    op(0, 16'h0015, 16'h0007, 2'b01);
    idle(16'h0015, 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [15:0] a, d;
      logic [1:0] be;
      bit rst;
      sel = $urandom_range(0, 15);
      if (sel <= 11 || sel == 15) a = BASE + 16'($urandom_range(0, NCH * 8 - 1));
      else if (sel == 12) a = BASE + 16'(NCH * 8) + 16'($urandom_range(0, 7));
      else if (sel == 13) a = 16'($urandom_range(0, 7));
      else a = 16'($urandom);
      if (decode_ch(a) >= 0 && ((int'(a) - int'(BASE)) % 8) == 5) begin
        d = 16'($urandom_range(0, 12));
        be = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
      end else begin
        d = 16'($urandom);
        be = 2'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      op(rst, a, d, be);
    end
    idle(16'h0008, 1);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_out_bank.md
# gpio_out_bank

Parametrised memory-mapped output port bank; the successor to the single fixed-address output register. It provides NCH independent 16-bit output channels. Each channel has atomic set/clear/toggle access, byte-enable writes and a hardware one-shot pulse timer with a sticky completion flag. It sits on the data-memory bus beside RAM and drives device pins; CPU readback is combinational.

## Interface
Parameters:
- NCH, 2: number of 16-bit output channels (1..8)
- BASE_ADDR, 16'h0008: address of channel 0 register 0; must be a multiple of 8
- CNT_W, 16: pulse counter width (1..16)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- bus_in  in  16  write data
- address  in  16  bus address, word granular
- MemWrite  in  2  byte write enables; [0] covers bits 7:0, [1] covers bits 15:8
- rd_data  out  16  combinational readback of the addressed register; 0 when the address is unmapped
- io_port  out  NCH*16  pin outputs; channel c occupies bits [16c+15:16c]
- pulse_done  out  NCH  per-channel sticky done flags; the STATUS bit, exported

## Operation
- Channel c decodes addresses BASE_ADDR + 8c + r. The 8-word stride per channel is fixed. Registers r:
  - 0 DATA: read/write
  - 1 SET: write ORs data into DATA
  - 2 CLR: write clears the written bits in DATA
  - 3 TGL: write XORs data into DATA
  - 4 PMASK: read/write pulse bit mask
  - 5 PLEN: read returns the remaining count, zero-extended
  - 6 STATUS: bit0 is done; writing 1 to bit0 clears it (W1C)
  - 7: reserved; reads 0, writes ignored
- Byte enables gate which bits of DATA, SET, CLR, TGL and PMASK are affected. Bits in an unenabled byte keep their value.
- A PLEN write takes effect only when MemWrite==2'b11; partial writes are ignored. Bits above CNT_W are ignored.
- Output: io_port_c = DATA ^ (cnt!=0 ? PMASK : 0). The output is registered and glitch-free.
- Pulse timer:
  - A PLEN write of N>0 loads cnt=N.
  - cnt decrements each cycle while nonzero.
  - On the 1→0 transition done is set.
  - A PLEN write of 0 aborts: cnt=0 and done is not set.
  - A write during an active pulse reloads the counter (retrigger).
- DATA and PMASK writes during an active pulse take effect immediately; the inversion follows the new values.
- Unmapped addresses and addresses of channel index ≥NCH: writes are ignored and rd_data=0.
- Reset value of every register, counter, done flag and output is 0.

## Timing
- Register write at edge k: DATA and io_port show the new value after edge k, i.e. 1-cycle write latency.
- PLEN=N written at edge k: the masked bits are inverted on io_port from after edge k to after edge k+N, which is exactly N cycles.
- pulse_done rises after edge k+N.
- Simultaneous events:
  - PLEN write on the expiry cycle: the reload wins and done is not set.
  - STATUS W1C on the same edge as expiry: set wins and done stays 1.
- rd_data is combinational from address and reflects register state before the current edge.
- Reset asserted mid-pulse: cnt, done and io_port are 0 at the next edge. Writes in the reset cycle are discarded.

## Structure
- Package gpio_out_pkg holds:
  - localparams REG_DATA..REG_STATUS (0..6)
  - CH_STRIDE=8
  - a register-offset enum type
- Sub-module gpio_out_channel: one channel's DATA, PMASK, counter, done flag and output register. It has inputs for a decoded write strobe per register, the byte enables and write data, and outputs the port and readback mux.
- Top level gpio_out_bank: address decode, a generate loop of NCH channels, and the readback OR-mux.

## Test plan
- Reset, then write DATA ch0 = 16'hA5C3 with MemWrite=2'b11 → io_port[15:0]=16'hA5C3 next cycle and rd_data=16'hA5C3.
- Byte enables, starting from DATA=16'hA5C3:
  - MemWrite=2'b01 with 16'hFF00 → DATA=16'hA500
  - then SET 16'h00F0 with 2'b11 → 16'hA5F0
  - CLR 16'hA000 → 16'h05F0
  - TGL 16'hFFFF with 2'b10 → 16'hFAF0
- Pulse on ch1: DATA=0, PMASK=16'h0001, PLEN=5 → io_port[16] high for exactly 5 cycles; pulse_done[1] rises on the 5th edge. STATUS write 1 → done clears.
- Retrigger and abort:
  - PLEN=10, then PLEN=3 after 4 cycles → the pulse totals 7 cycles and done is set.
  - PLEN=10, then PLEN=0 → the pulse ends and done stays 0.
- Collisions:
  - PLEN reload on the expiry cycle → no done.
  - W1C on the expiry edge → done=1.
  - Reset asserted mid-pulse → all outputs 0 next cycle.
- Address decode with NCH=2:
  - Write to BASE_ADDR+16 (channel 2), to r=7 and to 16'h0000 → no state change, rd_data=0.
  - PLEN write with MemWrite=2'b01 → ignored.
